cla_rr_arbiter: RTL

CLA_RR_ARBITER -- requirements
Module: cla_rr_arbiter

---
 rtl/cla_rr_arbiter_if.sv | 26 ++
 rtl/cla_rr_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/cla_rr_arbiter_if.sv
// Request/response bundle between four requesters and the shared-adder arbiter.
// The master side is the requester/consumer; the slave side is the arbiter.
interface cla_rr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 16
);
  logic [NREQ-1:0]         req;
  logic [NREQ*W-1:0]       a_in;
  logic [NREQ*W-1:0]       b_in;
  logic [NREQ-1:0]         ack;
  logic                    out_valid;
  logic                    out_ready;
  logic [$clog2(NREQ)-1:0] out_id;
  logic [W:0]              out_sum;
  logic                    busy;

  modport master (
    output req, a_in, b_in, out_ready,
    input  ack, out_valid, out_id, out_sum, busy
  );

  modport slave (
    input  req, a_in, b_in, out_ready,
    output ack, out_valid, out_id, out_sum, busy
  );
endinterface

// File: rtl/cla_rr_arbiter.sv
// Round-robin arbiter sharing one 16-bit carry-lookahead adder among four requesters.
// One operation at a time: IDLE grants and latches operands, EXEC adds, RESP holds the result.
module cla_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  cla_rr_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state_q, state_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [1:0]     gid_q, gid_d;
  logic [1:0]     out_id_q, out_id_d;
  logic [W-1:0]   opa_q, opa_d;
  logic [W-1:0]   opb_q, opb_d;
  logic [W:0]     sum_q, sum_d;
  logic [NREQ-1:0] ack_c;

  logic           found;
  logic [1:0]     win;
  logic [1:0]     idx;

  // Search starts at ptr and wraps; the first requesting index wins.
  always_comb begin : rr_pick
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  logic [W-1:0]   g, p, c;
  logic [3:0]     gg, pg;
  logic [4:0]     gc;
  logic [W:0]     cla_sum;

  // Two-level CLA: 4-bit group generate/propagate, lookahead across groups.
  always_comb begin : cla16
    g  = opa_q & opb_q;
    p  = opa_q ^ opb_q;
    gg = '0;
    pg = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
              (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg[k] = &p[4*k +: 4];
    end
    gc[0] = 1'b0;
    gc[1] = gg[0];
    gc[2] = gg[1] | (pg[1] & gg[0]);
    gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]);
    gc[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) | (pg[3] & pg[2] & pg[1] & gg[0]);
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    cla_sum = {gc[4], p ^ c};
  end

  always_comb begin : fsm_next
    state_d  = state_q;
    ptr_d    = ptr_q;
    gid_d    = gid_q;
    out_id_d = out_id_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    sum_d    = sum_q;
    ack_c    = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          // Gated by rst_n so ack drops the instant reset asserts.
          ack_c[win] = rst_n;
          state_d    = EXEC;
          ptr_d      = win + 2'd1;
          gid_d      = win;
          opa_d      = bus.a_in[win*W +: W];
          opb_d      = bus.b_in[win*W +: W];
        end
      end
      EXEC: begin
        sum_d    = cla_sum;
        out_id_d = gid_q;
        state_d  = RESP;
      end
      RESP: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gid_q    <= '0;
      out_id_q <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gid_q    <= gid_d;
      out_id_q <= out_id_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      sum_q    <= sum_d;
    end
  end

  assign bus.ack       = ack_c;
  assign bus.out_valid = (state_q == RESP);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_sum   = sum_q;
  assign bus.out_id    = out_id_q;

endmodule
